// File: rtl/instr_decode_stage.sv
// Instruction-decode stage: splits opcode/register fields, gathers a trailing
// immediate word for immediate-class opcodes, and emits one decoded instruction per handshake.
module instr_decode_stage #(
  parameter int                      INSTR_W    = 8,
  parameter int                      OPC_W      = 4,
  parameter int                      REG_W      = 2,
  parameter int                      DATA_W     = 8,
  parameter int                      PC_W       = 8,
  parameter logic [PC_W-1:0]         RESET_PC   = '0,
  parameter logic [(2**OPC_W)-1:0]   IMM_MASK   = 16'h000C,
  parameter logic [(2**OPC_W)-1:0]   LEGAL_MASK = 16'hFFFF,
  parameter bit                      IMM_SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_word,
  output logic               in_ready,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs,
  output logic [DATA_W-1:0]  out_imm,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal
);

  if (OPC_W + 2*REG_W > INSTR_W) begin : g_bad_fields
    $error("instr_decode_stage: opcode and register fields overlap");
  end
  if (DATA_W < INSTR_W) begin : g_bad_data_w
    $error("instr_decode_stage: DATA_W must be >= INSTR_W");
  end

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic               out_valid_q, out_ill_q;
  logic [OPC_W-1:0]   out_opc_q;
  logic [REG_W-1:0]   out_rd_q, out_rs_q;
  logic [DATA_W-1:0]  out_imm_q;
  logic [PC_W-1:0]    out_pc_q;
  logic [OPC_W-1:0]   hold_opc_q;
  logic [REG_W-1:0]   hold_rd_q, hold_rs_q;
  logic               hold_ill_q;
  logic [PC_W-1:0]    hold_pc_q;

  logic               accept;
  logic [OPC_W-1:0]   dec_opc;
  logic [REG_W-1:0]   dec_rd, dec_rs;
  logic               dec_imm, dec_ill;
  logic [DATA_W-1:0]  imm_ext;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign dec_opc  = in_word[INSTR_W-1 -: OPC_W];
  assign dec_rd   = in_word[2*REG_W-1:REG_W];
  assign dec_rs   = in_word[REG_W-1:0];
  assign dec_imm  = IMM_MASK[dec_opc];
  assign dec_ill  = !LEGAL_MASK[dec_opc];

  // Fill the upper bits first so DATA_W == INSTR_W needs no special case.
  always_comb begin
    imm_ext                = {DATA_W{IMM_SIGNED && in_word[INSTR_W-1]}};
    imm_ext[INSTR_W-1:0]   = in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OP;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_opc_q   <= '0;
      out_rd_q    <= '0;
      out_rs_q    <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= RESET_PC;
      out_ill_q   <= 1'b0;
      hold_opc_q  <= '0;
      hold_rd_q   <= '0;
      hold_rs_q   <= '0;
      hold_ill_q  <= 1'b0;
      hold_pc_q   <= '0;
    end else if (flush) begin
      state_q     <= S_OP;
      pc_q        <= flush_pc;
      out_valid_q <= 1'b0;
      hold_opc_q  <= '0;
      hold_rd_q   <= '0;
      hold_rs_q   <= '0;
      hold_ill_q  <= 1'b0;
      hold_pc_q   <= '0;
    end else if (accept) begin
      pc_q <= pc_q + PC_W'(1);
      unique case (state_q)
        S_OP: begin
          if (dec_imm) begin
            // Park the opcode fields; the output register can only drain here.
            hold_opc_q  <= dec_opc;
            hold_rd_q   <= dec_rd;
            hold_rs_q   <= dec_rs;
            hold_ill_q  <= dec_ill;
            hold_pc_q   <= pc_q;
            out_valid_q <= 1'b0;
            state_q     <= S_IMM;
          end else begin
            out_valid_q <= 1'b1;
            out_opc_q   <= dec_opc;
            out_rd_q    <= dec_rd;
            out_rs_q    <= dec_rs;
            out_imm_q   <= '0;
            out_pc_q    <= pc_q;
            out_ill_q   <= dec_ill;
          end
        end
        S_IMM: begin
          out_valid_q <= 1'b1;
          out_opc_q   <= hold_opc_q;
          out_rd_q    <= hold_rd_q;
          out_rs_q    <= hold_rs_q;
          out_imm_q   <= imm_ext;
          out_pc_q    <= hold_pc_q;
          out_ill_q   <= hold_ill_q;
          state_q     <= S_OP;
        end
        default: state_q <= S_OP;
      endcase
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opc_q;
  assign out_rd      = out_rd_q;
  assign out_rs      = out_rs_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_ill_q;

endmodule
